mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width.
REQ-002 Parameter DATA_W, default 4, memory data width.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 REQ0 / REQ1  input  1  each: requester 0/1 transaction request, held high until its ACK.
REQ-006 WE0 / WE1  input  1  each: 1 = write, 0 = read; valid while REQx high.
REQ-007 ADDR0 / ADDR1  input  ADDR_W  each: transaction address.
REQ-008 WDATA0 / WDATA1  input  DATA_W  each: write data.
REQ-009 ACK0 / ACK1  output  1  each: one-cycle completion pulse to requester 0/1.
REQ-010 RDATA0 / RDATA1  output  DATA_W  each: last read data returned to requester 0/1.
REQ-011 MEM_WR  output  1  memory write strobe.
REQ-012 MEM_RD  output  1  memory read strobe.
REQ-013 MEM_A  output  ADDR_W  memory address.
REQ-014 MEM_DIN  output  DATA_W  memory write data.
REQ-015 MEM_Q  input  DATA_W  memory read data; registered, valid the cycle after the edge sampling MEM_RD.
REQ-016 BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, CAPT, DONE; transitions ISSUE->CAPT->DONE->IDLE unconditional.
REQ-018 IDLE->ISSUE on any rising edge with REQ0 or REQ1 high; otherwise IDLE holds.
REQ-019 On the IDLE->ISSUE edge the winner's WEx, ADDRx, WDATAx and port ID are latched; later input changes have no effect on that transaction.
REQ-020 Single request: that port wins.
REQ-021 Both requesting: port not granted most recently wins (round-robin); after reset port 0 wins first tie.
REQ-022 Round-robin pointer updates only on a grant.
REQ-023 MEM_WR = 1 exactly during ISSUE with latched WE = 1; MEM_RD = 1 exactly during ISSUE with latched WE = 0; both 0 in all other states.
REQ-024 MEM_A and MEM_DIN drive latched address/data in ISSUE, CAPT and DONE; hold last values in IDLE.
REQ-025 Read: on the CAPT->DONE edge MEM_Q is loaded into RDATAx of the granted port; other port's RDATA unchanged.
REQ-026 Write: RDATA0/RDATA1 unchanged.
REQ-027 ACKx = 1 only during DONE for the granted port; never both high; ACK of the other port 0.
REQ-028 Latency: REQ sampled at edge N -> ISSUE cycle N+1, ACK high in cycle N+3, RDATAx valid from cycle N+3 and held until the next read for that port.
REQ-029 Throughput: one transaction per 4 cycles; REQ still high in the IDLE cycle after DONE is a new request.
REQ-030 Requester drops REQ on the edge ending its ACK cycle to issue a single transaction.
REQ-031 REQ deasserted by a non-granted port before being granted causes no transaction and no ACK.
REQ-032 Address wrap not applicable; all 2^ADDR_W addresses legal, including 0 and all-ones.

Reset
REQ-033 RST high immediately forces IDLE, regardless of clock.
REQ-034 During reset: ACK0 = ACK1 = 0, MEM_WR = MEM_RD = 0, MEM_A = 0, MEM_DIN = 0, RDATA0 = RDATA1 = 0, BUSY = 0, round-robin pointer = port 0 priority.
REQ-035 Reset during ISSUE drops the strobe before the next edge; an aborted transaction is never ACKed and RDATA is not updated.
REQ-036 First request is sampled on the first rising edge with RST low.

Verification
REQ-037 Port 0 writes A=0011 D=1001, then port 1 writes A=1101 D=1010 -> MEM_WR high one cycle each with matching MEM_A/MEM_DIN; ACK0 then ACK1 in cycle N+3 of each.
REQ-038 Port 0 reads 0011, port 1 reads 1101 -> RDATA0 = 1001, RDATA1 = 1010 when the respective ACK is high; the other RDATA is unchanged.
REQ-039 REQ0 and REQ1 both held high after reset -> grants alternate 0,1,0,1; ACKs spaced 4 cycles apart; no ACK overlap.
REQ-040 Only REQ1 held high for 3 transactions -> port 1 granted each time, ACK1 every 4 cycles, ACK0 stays 0.
REQ-041 RST asserted mid-ISSUE of a write to 0101 with D=1111 -> outputs go to reset values immediately, no ACK; a later read of 0101 does not return 1111 unless previously written.
REQ-042 Port 1 changes ADDR1/WDATA1 during ISSUE -> MEM_A/MEM_DIN keep the latched values.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a registered-output memory.
// The slave view belongs to the arbiter; the master view belongs to the requesters and memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_wr, mem_rd;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_din, mem_q;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
    output ack0, ack1, rdata0, rdata1, mem_wr, mem_rd, mem_a, mem_din, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
    input  ack0, ack1, rdata0, rdata1, mem_wr, mem_rd, mem_a, mem_din, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory with a one-cycle read latency.
// Each transaction takes four cycles: IDLE (grant), ISSUE (strobe), CAPT (data returns), DONE (ack).
module mem_arbiter_port #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              done,
  input  logic              load,
  input  logic [DATA_W-1:0] mem_q,
  output logic              ack,
  output logic [DATA_W-1:0] rdata
);
  assign ack = done & sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              rdata <= '0;
    else if (load && sel) rdata <= mem_q;
  end
endmodule

module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  state_t            state, state_nxt;
  logic              grant, winner, prio;
  logic              lat_we, lat_id;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic [NUM_PORTS-1:0]             ack_vec;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_vec;

  // prio names the port that wins a tie; it flips away from each winner
  always_comb begin
    winner = 1'b0;
    if (bus.req0 && bus.req1) winner = prio;
    else if (bus.req1)        winner = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt = ISSUE;
          grant     = 1'b1;
        end
      end
      ISSUE:   state_nxt = CAPT;
      CAPT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we   <= 1'b0;
      lat_id   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      prio     <= 1'b0;
    end else if (grant) begin
      lat_we   <= winner ? bus.we1    : bus.we0;
      lat_addr <= winner ? bus.addr1  : bus.addr0;
      lat_data <= winner ? bus.wdata1 : bus.wdata0;
      lat_id   <= winner;
      prio     <= ~winner;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    mem_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .clk   (clk),
      .rst   (rst),
      .sel   (lat_id == 1'(i)),
      .done  (state == DONE),
      .load  ((state == CAPT) && !lat_we),
      .mem_q (bus.mem_q),
      .ack   (ack_vec[i]),
      .rdata (rdata_vec[i])
    );
  end

  // strobes decode the state directly so an async reset kills them at once
  assign bus.mem_wr  = (state == ISSUE) &&  lat_we;
  assign bus.mem_rd  = (state == ISSUE) && !lat_we;
  assign bus.mem_a   = lat_addr;
  assign bus.mem_din = lat_data;
  assign bus.busy    = (state != IDLE);
  assign bus.ack0    = ack_vec[0];
  assign bus.ack1    = ack_vec[1];
  assign bus.rdata0  = rdata_vec[0];
  assign bus.rdata1  = rdata_vec[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected strobes and acks are queued as stimulus is issued
// and a negedge monitor pops and compares them against what the arbiter presents.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  mem_arbiter #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic we; logic [3:0] a; logic [3:0] d; } strobe_t;
  typedef struct { logic port; logic [3:0] r0; logic [3:0] r1; } ack_t;

  strobe_t strobe_q[$];
  ack_t    ack_q[$];
  int      strobe_cyc_q[$];
  int      checks = 0;
  int      fails  = 0;
  int      cyc    = 0;
  int      last_ack = -1;
  bit      b2b = 1'b0;
  logic [3:0] cur_a, cur_d;
  logic [3:0] mem [16];

  initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;

  // registered memory: read data appears the cycle after the read strobe is sampled
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_wr) mem[bus.mem_a] <= bus.mem_din;
    if (bus.mem_rd) bus.mem_q <= mem[bus.mem_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_wr || bus.mem_rd) begin
        if (strobe_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          strobe_t e;
          e = strobe_q.pop_front();
          chk("strobe_we", 32'(bus.mem_wr), 32'(e.we));
          chk("strobe_addr", 32'(bus.mem_a), 32'(e.a));
          if (e.we) chk("strobe_din", 32'(bus.mem_din), 32'(e.d));
          cur_a = bus.mem_a;
          cur_d = bus.mem_din;
          strobe_cyc_q.push_back(cyc);
        end
      end else if (bus.busy) begin
        chk("held_addr", 32'(bus.mem_a), 32'(cur_a));
        chk("held_din", 32'(bus.mem_din), 32'(cur_d));
      end
      if (bus.ack0 && bus.ack1) chk("ack_overlap", 1, 0);
      if (bus.ack0 || bus.ack1) begin
        if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          ack_t e;
          e = ack_q.pop_front();
          chk("ack_port", 32'(bus.ack1), 32'(e.port));
          chk("rdata0", 32'(bus.rdata0), 32'(e.r0));
          chk("rdata1", 32'(bus.rdata1), 32'(e.r1));
          if (strobe_cyc_q.size() == 0) chk("ack_without_strobe", 1, 0);
          else chk("ack_latency", 32'(cyc - strobe_cyc_q.pop_front()), 32'd2);
          if (b2b && last_ack >= 0) chk("ack_spacing", 32'(cyc - last_ack), 32'd4);
          last_ack = cyc;
        end
      end
    end
  end

  task automatic exp_txn(input logic we, input logic [3:0] a, input logic [3:0] d,
                         input logic port, input logic [3:0] r0, input logic [3:0] r1);
    strobe_t s;
    ack_t    k;
    s.we = we; s.a = a; s.d = d;
    k.port = port; k.r0 = r0; k.r1 = r1;
    strobe_q.push_back(s);
    ack_q.push_back(k);
  endtask

  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [3:0] a, input logic [3:0] d);
    if (p == 0) begin bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
  endtask

  // count n acks on port p, then drop its request on the edge that ends the last ack
  task automatic wait_acks(input int p, input int n);
    int got = 0;
    int budget = 0;
    while (got < n && budget < 200) begin
      @(negedge clk);
      budget++;
      if (p == 0 ? bus.ack0 : bus.ack1) got++;
    end
    chk($sformatf("ack_timeout_p%0d", p), 32'(got), 32'(n));
    @(posedge clk); #1;
    if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic port_txn(input int p, input logic we, input logic [3:0] a,
                          input logic [3:0] d, input int n);
    @(posedge clk); #1;
    set_port(p, 1'b1, we, a, d);
    wait_acks(p, n);
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, {bus.ack0, bus.ack1, bus.mem_wr, bus.mem_rd, bus.busy,
               bus.mem_a, bus.mem_din, bus.rdata0, bus.rdata1}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk_reset_outs("reset_outs");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    set_port(0, 1'b0, 1'b0, 4'h0, 4'h0);
    set_port(1, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1 chk_reset_outs("reset_state");
    rst = 1'b0;

    // writes then reads from each port, including addresses 0 and all-ones
    exp_txn(1, 4'h3, 4'h9, 0, 4'h0, 4'h0); port_txn(0, 1, 4'h3, 4'h9, 1);
    exp_txn(1, 4'hD, 4'hA, 1, 4'h0, 4'h0); port_txn(1, 1, 4'hD, 4'hA, 1);
    exp_txn(0, 4'h3, 4'h0, 0, 4'h9, 4'h0); port_txn(0, 0, 4'h3, 4'h0, 1);
    exp_txn(0, 4'hD, 4'h0, 1, 4'h9, 4'hA); port_txn(1, 0, 4'hD, 4'h0, 1);
    exp_txn(1, 4'hF, 4'h7, 0, 4'h9, 4'hA); port_txn(0, 1, 4'hF, 4'h7, 1);
    exp_txn(1, 4'h0, 4'h3, 1, 4'h9, 4'hA); port_txn(1, 1, 4'h0, 4'h3, 1);
    exp_txn(0, 4'hF, 4'h0, 0, 4'h7, 4'hA); port_txn(0, 0, 4'hF, 4'h0, 1);
    exp_txn(0, 4'h0, 4'h0, 1, 4'h7, 4'h3); port_txn(1, 0, 4'h0, 4'h0, 1);

    // port 1 changes its address/data while its write is in ISSUE
    exp_txn(1, 4'h6, 4'h4, 1, 4'h7, 4'h3);
    @(posedge clk); #1;
    set_port(1, 1'b1, 1'b1, 4'h6, 4'h4);
    @(posedge clk); #1;
    bus.addr1 = 4'hF; bus.wdata1 = 4'hF;
    wait_acks(1, 1);
    exp_txn(0, 4'h6, 4'h0, 0, 4'h4, 4'h3); port_txn(0, 0, 4'h6, 4'h0, 1);

    // both held after reset: grants alternate starting with port 0
    pulse_reset();
    last_ack = -1; b2b = 1'b1;
    exp_txn(1, 4'h1, 4'h1, 0, 4'h0, 4'h0);
    exp_txn(1, 4'h2, 4'h2, 1, 4'h0, 4'h0);
    exp_txn(1, 4'h1, 4'h1, 0, 4'h0, 4'h0);
    exp_txn(1, 4'h2, 4'h2, 1, 4'h0, 4'h0);
    fork
      port_txn(0, 1, 4'h1, 4'h1, 2);
      port_txn(1, 1, 4'h2, 4'h2, 2);
    join

    // only port 1 held for three reads
    @(posedge clk);
    last_ack = -1;
    for (int i = 0; i < 3; i++) exp_txn(0, 4'h2, 4'h0, 1, 4'h0, 4'h2);
    port_txn(1, 0, 4'h2, 4'h0, 3);
    b2b = 1'b0;

    // port 1 pulses a request while port 0 is busy and withdraws before any grant
    exp_txn(0, 4'h1, 4'h0, 0, 4'h1, 4'h2);
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b0, 4'h1, 4'h0);
    @(posedge clk); #1;
    set_port(1, 1'b1, 1'b0, 4'h9, 4'h0);
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    wait_acks(0, 1);
    repeat (6) @(negedge clk);
    chk("idle_after_withdraw", 32'(bus.busy), 32'd0);

    // reset lands in the middle of ISSUE of a write to 0101
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b1, 4'h5, 4'hF);
    @(posedge clk); #2;
    chk("issue_wr_before_reset", 32'(bus.mem_wr), 32'd1);
    rst = 1'b1;
    #1 chk_reset_outs("reset_mid_issue");
    bus.req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_busy_after_abort", 32'(bus.busy), 32'd0);
    exp_txn(0, 4'h5, 4'h0, 1, 4'h0, 4'h0); port_txn(1, 0, 4'h5, 4'h0, 1);

    repeat (4) @(posedge clk);
    chk("strobes_outstanding", 32'(strobe_q.size()), 32'd0);
    chk("acks_outstanding", 32'(ack_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
